instruction_fetch_stage: RTL and testbench

IF-stage initiator for the pipeline's combinational instruction memory. It owns the program counter and drives the word-aligned fetch address. It captures the returned instruction word into the IF/ID pipeline register. It also applies stall, flush, branch redirect and halt requests from the ID stage and the hazard unit.

---
 rtl/instruction_fetch_stage_pkg.sv | 25 ++
 rtl/instruction_fetch_stage_if.sv | 10 +
 rtl/instruction_fetch_stage_pc_next_sel.sv | 52 +++++
 rtl/instruction_fetch_stage.sv | 124 ++++++++++++
 tb/tb_instruction_fetch_stage.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared IF-stage types: fetch FSM encoding, IF/ID register layout and per-edge IF/ID action.
package instruction_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_CAPTURE = 2'd2
  } if_act_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory fetch bus: address out, combinational instruction word back.
interface instruction_fetch_stage_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] imem_pc;
  logic [31:0]       imem_instr;

  modport master (output imem_pc, input imem_instr);
  modport slave  (input imem_pc, output imem_instr);
endinterface

// File: rtl/instruction_fetch_stage_pc_next_sel.sv
// Combinational next-PC mux and IF/ID action select.
// Priority in RUN: branch > halt > stall > flush > normal; BOOT and HALT always bubble.
module instruction_fetch_stage_pc_next_sel
  import instruction_fetch_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  fetch_state_e      i_state,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_halt,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic [ADDR_W-1:0] o_pc_next,
  output if_act_e           o_act,
  output logic              o_halt_req
);

  logic [ADDR_W-1:0] w_pc_plus4;
  logic              w_unused;

  assign w_pc_plus4 = i_pc + ADDR_W'(4);
  assign w_unused   = ^i_branch_target[1:0];

  always_comb begin
    o_pc_next  = i_pc;
    o_act      = ACT_HOLD;
    o_halt_req = 1'b0;
    case (i_state)
      ST_RUN: begin
        if (i_branch_taken) begin
          o_pc_next = {i_branch_target[ADDR_W-1:2], 2'b00};
          o_act     = ACT_BUBBLE;
        end else if (i_halt) begin
          o_act      = ACT_BUBBLE;
          o_halt_req = 1'b1;
        end else if (i_stall) begin
          o_act = ACT_HOLD;
        end else if (i_flush) begin
          o_pc_next = w_pc_plus4;
          o_act     = ACT_BUBBLE;
        end else begin
          o_pc_next = w_pc_plus4;
          o_act     = ACT_CAPTURE;
        end
      end
      default: o_act = ACT_BUBBLE;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, fetches from combinational imem, fills the IF/ID register (1-clock latency).
// Optional IF_PERF_COUNTERS_EN adds saturating fetch/bubble counters.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_stage_if.master imem,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      branch_taken,
  input  logic [ADDR_W-1:0]         branch_target,
  input  logic                      halt,
  output logic [ADDR_W-1:0]         if_id_pc,
  output logic [ADDR_W-1:0]         if_id_pc_plus4,
  output logic [31:0]               if_id_instr,
  output logic                      if_id_valid,
  output logic [1:0]                fetch_state
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0]               perf_fetch_cnt,
  output logic [31:0]               perf_bubble_cnt
`endif
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  if_act_e           w_act;
  logic              w_halt_req;
  logic [ADDR_W-1:0] r_if_id_pc;
  logic [ADDR_W-1:0] r_if_id_pc_plus4;
  logic [31:0]       r_if_id_instr;
  logic              r_if_id_valid;

  instruction_fetch_stage_pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
    .i_state         (r_state),
    .i_pc            (r_pc),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_halt          (halt),
    .i_stall         (stall),
    .i_flush         (flush),
    .o_pc_next       (w_pc_next),
    .o_act           (w_act),
    .o_halt_req      (w_halt_req)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_BOOT;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BOOT: w_state_next = ST_RUN;
      ST_RUN:  if (w_halt_req) w_state_next = ST_HALT;
      ST_HALT: w_state_next = ST_HALT;
      default: w_state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc             <= RESET_PC;
      r_if_id_pc       <= '0;
      r_if_id_pc_plus4 <= '0;
      r_if_id_instr    <= NOP_INSTR;
      r_if_id_valid    <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      case (w_act)
        ACT_CAPTURE: begin
          r_if_id_pc       <= r_pc;
          r_if_id_pc_plus4 <= r_pc + ADDR_W'(4);
          r_if_id_instr    <= imem.imem_instr;
          r_if_id_valid    <= 1'b1;
        end
        ACT_BUBBLE: begin
          r_if_id_pc       <= '0;
          r_if_id_pc_plus4 <= '0;
          r_if_id_instr    <= NOP_INSTR;
          r_if_id_valid    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_bubble_cnt;

  // Only RUN-state bubbles (branch/flush/halt request) count; BOOT and parked HALT cycles do not.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetch_cnt  <= '0;
      r_perf_bubble_cnt <= '0;
    end else begin
      if (w_act == ACT_CAPTURE && r_perf_fetch_cnt != 32'hFFFF_FFFF)
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      if (r_state == ST_RUN && w_act == ACT_BUBBLE && r_perf_bubble_cnt != 32'hFFFF_FFFF)
        r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt  = r_perf_fetch_cnt;
  assign perf_bubble_cnt = r_perf_bubble_cnt;
`endif

  assign imem.imem_pc    = r_pc;
  assign if_id_pc        = r_if_id_pc;
  assign if_id_pc_plus4  = r_if_id_pc_plus4;
  assign if_id_instr     = r_if_id_instr;
  assign if_id_valid     = r_if_id_valid;
  assign fetch_state     = r_state;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a combinational 256-word instruction memory.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, branch_taken, halt;
  logic [31:0] branch_target;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;
  logic        if_id_valid;
  logic [1:0]  fetch_state;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mem [256];

  instruction_fetch_stage_if #(.ADDR_W(32)) imem_bus ();

  assign imem_bus.imem_instr = mem[imem_bus.imem_pc[9:2]];

  instruction_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (imem_bus.master),
    .stall          (stall),
    .flush          (flush),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .halt           (halt),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid),
    .fetch_state    (fetch_state)
`ifdef IF_PERF_COUNTERS_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge before checking/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, 32'd0);
    chk({tag, ".instr"}, if_id_instr, 32'h0);
    chk({tag, ".pc"}, if_id_pc, 32'h0);
    chk({tag, ".pc4"}, if_id_pc_plus4, 32'h0);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0100_0000 | k;
    mem[0] = 32'h0; mem[1] = 32'h0; mem[2] = 32'h0;
    mem[3] = 32'h8C01_0000;

    reset = 1'b1; stall = 0; flush = 0; branch_taken = 0; halt = 0; branch_target = 32'h0;
    step(); step();
    chk("rst.state", {30'b0, fetch_state}, 32'd0);
    chk("rst.pc", imem_bus.imem_pc, 32'h0);
    chk_bubble("rst");

    reset = 1'b0;
    step();
    chk("boot.state", {30'b0, fetch_state}, 32'd1);
    chk("boot.pc", imem_bus.imem_pc, 32'h0);
    chk("boot.valid", {31'b0, if_id_valid}, 32'd0);
    step(); chk("run.pc4", imem_bus.imem_pc, 32'h4);
    chk("run.cap0.valid", {31'b0, if_id_valid}, 32'd1);
    step(); chk("run.pc8", imem_bus.imem_pc, 32'h8);
    step(); chk("run.pcC", imem_bus.imem_pc, 32'hC);
    step();
    chk("lw.pc", if_id_pc, 32'hC);
    chk("lw.instr", if_id_instr, 32'h8C01_0000);
    chk("lw.valid", {31'b0, if_id_valid}, 32'd1);
    chk("lw.pc4", if_id_pc_plus4, 32'h10);

    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall.pc", imem_bus.imem_pc, 32'h10);
      chk("stall.ifid_pc", if_id_pc, 32'hC);
      chk("stall.instr", if_id_instr, 32'h8C01_0000);
    end
    stall = 1'b0;
    step();
    chk("resume.ifid_pc", if_id_pc, 32'h10);
    chk("resume.instr", if_id_instr, 32'h0100_0004);
    chk("resume.pc", imem_bus.imem_pc, 32'h14);

    for (int k = 0; k < 8; k++) step();
    chk("pre_br.pc", imem_bus.imem_pc, 32'h34);
    branch_taken = 1'b1; branch_target = 32'h0000_000E; stall = 1'b1;
    step();
    chk("br.pc", imem_bus.imem_pc, 32'hC);
    chk_bubble("br");
    branch_taken = 1'b0; stall = 1'b0;
    step();
    chk("br.cap_pc", if_id_pc, 32'hC);
    chk("br.cap_instr", if_id_instr, 32'h8C01_0000);

    for (int k = 0; k < 4; k++) step();
    chk("pre_fl.pc", imem_bus.imem_pc, 32'h20);
    flush = 1'b1;
    step();
    chk("fl.pc", imem_bus.imem_pc, 32'h24);
    chk_bubble("fl");
    flush = 1'b0;
    step();
    chk("fl.cap", if_id_pc, 32'h24);
    flush = 1'b1; stall = 1'b1;
    step();
    chk("flst.pc", imem_bus.imem_pc, 32'h28);
    chk("flst.ifid_pc", if_id_pc, 32'h24);
    chk("flst.valid", {31'b0, if_id_valid}, 32'd1);
    flush = 1'b0; stall = 1'b0;

    halt = 1'b1;
    step();
    chk("halt.state", {30'b0, fetch_state}, 32'd2);
    chk_bubble("halt");
    halt = 1'b0; branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("halt.hold_pc", imem_bus.imem_pc, 32'h28);
    end
    chk("halt.stay", {30'b0, fetch_state}, 32'd2);
    chk("halt.valid", {31'b0, if_id_valid}, 32'd0);

    reset = 1'b1;
    step();
    chk("hrst.pc", imem_bus.imem_pc, 32'h0);
    chk("hrst.state", {30'b0, fetch_state}, 32'd0);
`ifdef IF_PERF_COUNTERS_EN
    chk("perf.rst_fetch", perf_fetch_cnt, 32'd0);
    chk("perf.rst_bubble", perf_bubble_cnt, 32'd0);
`endif
    reset = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    step();
    chk("wrap.run", {30'b0, fetch_state}, 32'd1);
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    step();
    chk("wrap.pc", imem_bus.imem_pc, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    step();
    chk("wrap.next_pc", imem_bus.imem_pc, 32'h0);
    chk("wrap.ifid_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap.pc4", if_id_pc_plus4, 32'h0);
    chk("wrap.instr", if_id_instr, 32'h0100_00FF);
`ifdef IF_PERF_COUNTERS_EN
    chk("perf.fetch", perf_fetch_cnt, 32'd1);
    chk("perf.bubble", perf_bubble_cnt, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
